mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised WIDTH-bit modulo up/down counter with synchronous load, count enable and wrap/saturate mode.
- Successor to the fixed 3-bit adder and single-bit flip-flop utilities.
- Serves as the general counting primitive for timers, digit counters and address sequencers.
- Instances cascade through a combinational terminal-count output, for example two MAX=9 stages form a 00..99 counter.

Parameters:
- WIDTH, 4: counter bit width (≥2).
- MAX, 9: largest legal count value; 0 < MAX ≤ 2^WIDTH-1.
- WRAP, 1: 1 = modulo wrap at the bounds; 0 = saturate at the bounds.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; gates up/down steps only.
- mode  input  2  00 hold, 01 up, 10 down, 11 load.
- load_val  input  WIDTH  value written when mode=11.
- count  output  WIDTH  current count (registered).
- tc  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse, set when a bound was crossed or hit.
- load_err  output  1  registered one-cycle pulse, set when load_val > MAX.

Behaviour:
- Reset: reset_n=0 forces count=0, wrap=0, load_err=0 immediately, independent of clk. The state holds while reset_n is low.
- Reset release: the first update occurs on the first falling clk edge with reset_n=1.
- Update timing: all registers update on the falling edge of clk. There is no other sequential element.
- Output latency: count, wrap and load_err reflect the inputs sampled at the previous falling edge.
- wrap and load_err default to 0 every cycle unless set by the rules below, so each is a single-cycle pulse.
- mode=00: hold.
- mode=01, en=1:
  - count<MAX: count+1.
  - count==MAX and WRAP=1: count becomes 0 and wrap=1.
  - count==MAX and WRAP=0: count stays MAX and wrap=1.
- mode=10, en=1:
  - count>0: count-1.
  - count==0 and WRAP=1: count becomes MAX and wrap=1.
  - count==0 and WRAP=0: count stays 0 and wrap=1.
- mode=01/10 with en=0: hold; wrap=0.
- mode=11 (load): ignores en.
  - load_val ≤ MAX: count=load_val.
  - load_val > MAX: count=MAX and load_err=1.
  - wrap=0 on any load.
- Combinational terminal count: tc = en & ((mode==01 & count==MAX) | (mode==10 & count==0)). It has no register.
- Cascading: drive the higher stage's en from the lower stage's tc, and share mode. Both stages then step on the same edge.
- Range invariant: count never leaves 0..MAX, because load clamps and the steps are bounded.
- Arithmetic:
  - All arithmetic is WIDTH bits, and the adder carry-out is unused.
  - Increment is count + 0 with c_in=1.
  - Decrement is count + all-ones with c_in=0 (two's complement −1).
  - The bound comparisons are equality checks against MAX and 0. They are not taken from the adder carry.
- Reset mid-operation: asynchronous assertion aborts any pending step or load. No wrap or load_err pulse survives reset.
- Illegal parameters: MAX > 2^WIDTH-1 or MAX=0 is a configuration error, checked by an elaboration-time assertion.

Decomposition:
- Shared package holds:
  - the mode encodings MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11;
  - a parameter-check helper.
- Sub-module cla_adder: WIDTH-parametrised carry-lookahead adder (inputs x, y, c_in; outputs out, c_out).
  - Generalises the existing 3-bit adder.
  - Generates the per-bit p/g terms and a lookahead carry chain.
  - Instantiated once, with y and c_in chosen by a mode mux.
- The next-state select (hold/inc/dec/wrap/load/clamp) and the registers live in mod_counter.

Test Plan:
1. Reset then count up: WIDTH=4, MAX=9, WRAP=1; reset_n pulse low; mode=01, en=1 for 12 falling edges.
   - Expected: count 1,2,…,9,0,1,2.
   - Expected: wrap high only in the cycle after 9→0.
   - Expected: tc high while count==9.
2. Down wrap and saturate:
   - WRAP=1: count=0, mode=10 gives count=9 and wrap=1.
   - WRAP=0: same stimulus leaves count at 0 with wrap=1 each edge.
   - WRAP=0 with count=9 and mode=01: count stays 9.
3. Load clamp: MAX=9; mode=11, load_val=6 gives count=6, load_err=0.
   - load_val=12 gives count=9, load_err=1 for one cycle.
   - A load with en=0 still loads.
4. Enable gating: count=5, mode=01, en=0 for 3 edges.
   - Expected: count stays 5, tc=0, wrap=0.
5. Asynchronous reset mid-count: count=7, assert reset_n low between edges.
   - Expected: count=0 before the next falling edge.
   - Expected: count holds at 0 while low.
   - Expected: after release, first increment gives 1.
6. Cascade: two MAX=9 instances, high stage en = low stage tc, mode=01 for 100 edges from 00.
   - Expected: the pair sequences 00→99→00.
   - Expected: high stage wrap pulses once, at 99→00.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
// Shared definitions for the modulo counter slice.
//   mode_e        : operating mode encoding driven on mod_counter.mode
//   params_legal  : elaboration-time check of the WIDTH/MAX combination
package mod_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // A counter needs at least two bits, and MAX must be a non-zero value
    // that fits in WIDTH bits.
    function automatic bit params_legal(input int width, input int max_val);
        longint unsigned limit;
        if (width < 2) begin
            return 1'b0;
        end
        if (max_val <= 0) begin
            return 1'b0;
        end
        limit = (64'd1 << width) - 64'd1;
        return (longint'(max_val) <= longint'(limit));
    endfunction

endpackage

// File: rtl/cla_adder.sv
// cla_adder
// WIDTH-bit carry-lookahead adder: out = x + y + c_in.
// Ports:
//   x, y   [WIDTH-1:0] in  : operands
//   c_in            in  : carry into bit 0
//   out    [WIDTH-1:0] out : sum
//   c_out           out : carry out of the top bit
module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] out,
    output logic             c_out
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   carry;

    // Carry into bit k+1, expanded as a flat sum of products:
    //   g[k] | p[k]g[k-1] | ... | p[k]..p[1]g[0] | p[k]..p[0]c_in
    // Every carry depends only on p, g and c_in, never on a lower carry.
    function automatic logic lookahead(input int k,
                                       input logic [WIDTH-1:0] pp,
                                       input logic [WIDTH-1:0] gg,
                                       input logic cin);
        logic term;
        logic prop;
        term = 1'b0;
        prop = 1'b1;
        for (int j = k; j >= 0; j--) begin
            term = term | (prop & gg[j]);
            prop = prop & pp[j];
        end
        return term | (prop & cin);
    endfunction

    assign p        = x ^ y;
    assign g        = x & y;
    assign carry[0] = c_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
        assign carry[gi+1] = lookahead(gi, p, g, c_in);
    end

    assign out   = p ^ carry[WIDTH-1:0];
    assign c_out = carry[WIDTH];

endmodule

// File: rtl/mod_counter.sv
// mod_counter
// WIDTH-bit modulo up/down counter with load, enable and wrap/saturate mode.
// All state changes on the falling edge of clk; reset_n clears asynchronously.
// Ports:
//   clk       in         : clock (falling edge active)
//   reset_n   in         : asynchronous active-low reset
//   en        in         : enable for up/down steps (load ignores it)
//   mode      in  [1:0]  : 00 hold, 01 up, 10 down, 11 load
//   load_val  in  [W-1:0]: value loaded in mode 11, clamped to MAX
//   count     out [W-1:0]: registered count, always within 0..MAX
//   tc        out        : combinational terminal count for cascading
//   wrap      out        : one-cycle pulse after a step hit or crossed a bound
//   load_err  out        : one-cycle pulse after a load with load_val > MAX
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 9,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (!params_legal(WIDTH, MAX)) begin : g_bad_params
        $error("mod_counter: MAX must satisfy 0 < MAX <= 2**WIDTH-1 and WIDTH >= 2");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    mode_e            mode_sel;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             load_err_reg, load_err_next;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             unused_carry;

    assign mode_sel = mode_e'(mode);
    assign at_max   = (count_reg == MAX_V);
    assign at_zero  = (count_reg == '0);

    // One adder serves both directions: +1 is count + 0 + carry-in,
    // -1 is count + all-ones with no carry-in.
    always_comb begin
        add_y   = '0;
        add_cin = 1'b1;
        if (mode_sel == MODE_DOWN) begin
            add_y   = '1;
            add_cin = 1'b0;
        end
    end

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x     (count_reg),
        .y     (add_y),
        .c_in  (add_cin),
        .out   (add_sum),
        .c_out (unused_carry)
    );

    always_comb begin
        count_next    = count_reg;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        unique case (mode_sel)
            MODE_UP: begin
                if (en) begin
                    if (at_max) begin
                        wrap_next  = 1'b1;
                        count_next = WRAP ? '0 : MAX_V;
                    end else begin
                        count_next = add_sum;
                    end
                end
            end
            MODE_DOWN: begin
                if (en) begin
                    if (at_zero) begin
                        wrap_next  = 1'b1;
                        count_next = WRAP ? MAX_V : '0;
                    end else begin
                        count_next = add_sum;
                    end
                end
            end
            MODE_LOAD: begin
                // Out-of-range loads clamp so count never leaves 0..MAX.
                if (load_val > MAX_V) begin
                    count_next    = MAX_V;
                    load_err_next = 1'b1;
                end else begin
                    count_next = load_val;
                end
            end
            default: begin
                count_next = count_reg;
            end
        endcase
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg    <= '0;
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            wrap_reg     <= wrap_next;
            load_err_reg <= load_err_next;
        end
    end

    assign count    = count_reg;
    assign wrap     = wrap_reg;
    assign load_err = load_err_reg;
    assign tc       = en & (((mode_sel == MODE_UP) & at_max) |
                            ((mode_sel == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter
// Drives a wrapping and a saturating counter with identical stimulus and
// compares both against a behavioural model; also checks a two-stage
// 00..99 cascade built from two MAX=9 counters.
module tb_mod_counter;

    localparam int W  = 4;
    localparam int MX = 9;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] load_val;

    logic [W-1:0] cnt_w, cnt_s;
    logic         tc_w, tc_s, wrap_w, wrap_s, lerr_w, lerr_s;

    logic [1:0]   c_mode;
    logic [W-1:0] cnt_lo, cnt_hi;
    logic         tc_lo, tc_hi, wrap_lo, wrap_hi, lerr_lo, lerr_hi;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index 0 = wrapping instance, 1 = saturating instance.
    int m_cnt  [2];
    int m_wrap [2];
    int m_lerr [2];

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(W), .MAX(MX), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .load_val(load_val),
        .count(cnt_w), .tc(tc_w), .wrap(wrap_w), .load_err(lerr_w)
    );

    mod_counter #(.WIDTH(W), .MAX(MX), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .load_val(load_val),
        .count(cnt_s), .tc(tc_s), .wrap(wrap_s), .load_err(lerr_s)
    );

    mod_counter #(.WIDTH(W), .MAX(MX), .WRAP(1'b1)) u_lo (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .mode(c_mode), .load_val(4'd0),
        .count(cnt_lo), .tc(tc_lo), .wrap(wrap_lo), .load_err(lerr_lo)
    );

    mod_counter #(.WIDTH(W), .MAX(MX), .WRAP(1'b1)) u_hi (
        .clk(clk), .reset_n(reset_n), .en(tc_lo), .mode(c_mode), .load_val(4'd0),
        .count(cnt_hi), .tc(tc_hi), .wrap(wrap_hi), .load_err(lerr_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_wrap[k] = 0;
            m_lerr[k] = 0;
        end
    endtask

    // Behavioural rules applied to instance k on one falling edge.
    task automatic model_update(input int k, input int m, input int e, input int lv);
        bit wraps;
        wraps     = (k == 0);
        m_wrap[k] = 0;
        m_lerr[k] = 0;
        if (m == 1 && e != 0) begin
            if (m_cnt[k] < MX) m_cnt[k] = m_cnt[k] + 1;
            else begin
                m_wrap[k] = 1;
                m_cnt[k]  = wraps ? 0 : MX;
            end
        end else if (m == 2 && e != 0) begin
            if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
            else begin
                m_wrap[k] = 1;
                m_cnt[k]  = wraps ? MX : 0;
            end
        end else if (m == 3) begin
            if (lv > MX) begin
                m_cnt[k]  = MX;
                m_lerr[k] = 1;
            end else begin
                m_cnt[k] = lv;
            end
        end
    endtask

    function automatic int model_tc(input int k, input int m, input int e);
        return (e != 0 && ((m == 1 && m_cnt[k] == MX) || (m == 2 && m_cnt[k] == 0))) ? 1 : 0;
    endfunction

    // One transaction: drive at the rising edge, check tc before the falling
    // edge, then check the registered outputs at the next rising edge.
    task automatic step(input logic [1:0] m, input logic e, input logic [W-1:0] lv);
        mode     = m;
        en       = e;
        load_val = lv;
        #1;
        chk("tc_wrap", {31'd0, tc_w}, model_tc(0, m, e));
        chk("tc_sat",  {31'd0, tc_s}, model_tc(1, m, e));
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_update(k, m, e, lv);
        @(posedge clk);
        chk("count_wrap", {28'd0, cnt_w},  m_cnt[0]);
        chk("wrap_wrap",  {31'd0, wrap_w}, m_wrap[0]);
        chk("lerr_wrap",  {31'd0, lerr_w}, m_lerr[0]);
        chk("count_sat",  {28'd0, cnt_s},  m_cnt[1]);
        chk("wrap_sat",   {31'd0, wrap_s}, m_wrap[1]);
        chk("lerr_sat",   {31'd0, lerr_s}, m_lerr[1]);
        $display("txn mode=%0d en=%0d ld=%0d | wrap-inst cnt=%0d w=%0d le=%0d | sat-inst cnt=%0d w=%0d le=%0d",
                 m, e, lv, cnt_w, wrap_w, lerr_w, cnt_s, wrap_s, lerr_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int v;
        int hi_pulses;

        reset_n  = 1'b0;
        en       = 1'b0;
        mode     = 2'b00;
        load_val = '0;
        c_mode   = 2'b00;
        model_reset();

        repeat (2) @(posedge clk);
        chk("reset_count", {28'd0, cnt_w}, 0);
        chk("reset_wrap",  {31'd0, wrap_w}, 0);
        chk("reset_lerr",  {31'd0, lerr_s}, 0);
        reset_n = 1'b1;

        // Count up through the wrap point (1..9,0,1,2 on the wrapping instance).
        for (int i = 0; i < 12; i++) step(2'b01, 1'b1, '0);
        chk("up12_final", {28'd0, cnt_w}, 2);

        // Down from zero: wrapping goes to MAX, saturating stays at zero.
        step(2'b11, 1'b0, 4'd0);
        step(2'b10, 1'b1, '0);
        chk("down_wrap_to_max", {28'd0, cnt_w}, MX);
        chk("down_sat_hold0",   {28'd0, cnt_s}, 0);
        step(2'b11, 1'b1, 4'd0);
        step(2'b10, 1'b1, '0);
        step(2'b10, 1'b1, '0);

        // Saturate at MAX while counting up.
        step(2'b11, 1'b1, 4'd9);
        step(2'b01, 1'b1, '0);
        chk("up_sat_hold9", {28'd0, cnt_s}, MX);

        // Loads: in range, clamped, and with enable low.
        step(2'b11, 1'b1, 4'd6);
        chk("load6", {28'd0, cnt_w}, 6);
        step(2'b11, 1'b1, 4'd12);
        chk("load12_clamp", {28'd0, cnt_w}, MX);
        chk("load12_err",   {31'd0, lerr_w}, 1);
        step(2'b11, 1'b0, 4'd3);
        chk("load_en0", {28'd0, cnt_s}, 3);

        // Enable gating.
        step(2'b11, 1'b1, 4'd5);
        for (int i = 0; i < 3; i++) step(2'b01, 1'b0, '0);

        // Asynchronous reset between edges, with a load_err pulse pending.
        step(2'b11, 1'b1, 4'd7);
        step(2'b11, 1'b1, 4'd15);
        mode = 2'b01;
        en   = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", {28'd0, cnt_w}, 0);
        chk("async_rst_lerr",  {31'd0, lerr_w}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        chk("rst_hold_count", {28'd0, cnt_s}, 0);
        reset_n = 1'b1;
        step(2'b01, 1'b1, '0);
        chk("first_after_rst", {28'd0, cnt_w}, 1);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        // Cascade 00 -> 99 -> 00.
        mode      = 2'b00;
        c_mode    = 2'b01;
        v         = 0;
        hi_pulses = 0;
        chk("casc_start", {24'd0, cnt_hi, cnt_lo}, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            v = (v + 1) % 100;
            @(posedge clk);
            chk("casc_value", cnt_hi * 10 + cnt_lo, v);
            chk("casc_hi_wrap", {31'd0, wrap_hi}, (v == 0) ? 1 : 0);
            if (wrap_hi) hi_pulses++;
            $display("txn cascade edge=%0d value=%0d%0d hi_wrap=%0d", i + 1, cnt_hi, cnt_lo, wrap_hi);
        end
        chk("casc_hi_pulses", hi_pulses, 1);
        c_mode = 2'b00;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
